// File: rtl/inst_mem_resp.sv
// rtl/inst_mem_resp.sv - fetch-side instruction store with byte-stream program loader
// Same-cycle reads for the fetch unit; the loader holds the core while it fills the store.
module inst_mem_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          AW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   pc_i,
  output logic [31:0]   inst_o,
  output logic          fetch_err_o,
  output logic          hold_o,
  input  logic          ld_start_i,
  input  logic [AW-1:0] ld_base_i,
  input  logic [15:0]   ld_len_i,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_data_i,
  output logic          ld_ready_o,
  input  logic          ld_abort_i,
  output logic          ld_done_o,
  output logic          ld_err_o
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [23:0]   word_q, word_d;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem [DEPTH];
  logic          busy;
  logic [31:0]   diff;
  logic [AW-1:0] rd_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_cnt_q  <= 2'd0;
      waddr_q     <= '0;
      remaining_q <= 16'd0;
      word_q      <= 24'd0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      waddr_q     <= waddr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
    end
  end

  // Storage is deliberately unreset so it maps onto a plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr_q] <= mem_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    waddr_d     = waddr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    mem_we      = 1'b0;
    mem_wdata   = {ld_data_i, word_q};
    ld_ready_o  = 1'b0;
    ld_done_o   = 1'b0;
    ld_err_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_start_i) begin
          waddr_d     = ld_base_i;
          remaining_d = ld_len_i;
          byte_cnt_d  = 2'd0;
          state_d     = (ld_len_i == 16'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        ld_ready_o = 1'b1;
        // Abort wins over a byte offered in the same cycle.
        if (ld_abort_i) begin
          ld_err_o   = 1'b1;
          byte_cnt_d = 2'd0;
          state_d    = IDLE;
        end else if (ld_valid_i) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = ld_data_i;
            2'd1: word_d[15:8]  = ld_data_i;
            2'd2: word_d[23:16] = ld_data_i;
            default: begin
              mem_we      = 1'b1;
              waddr_d     = waddr_q + AW'(1);
              remaining_d = remaining_q - 16'd1;
              if (remaining_q == 16'd1) begin
                state_d = DONE;
              end
            end
          endcase
        end
      end
      DONE: begin
        ld_done_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign hold_o = busy;

  // Range check on the full 32-bit offset so aliases above the array are rejected.
  assign diff        = pc_i - BASE_ADDR;
  assign fetch_err_o = (pc_i[1:0] != 2'b00) || (pc_i < BASE_ADDR) || ({1'b0, diff} >= SPAN);
  assign rd_index    = diff[AW+1:2];
  assign inst_o      = (fetch_err_o || busy) ? NOP : mem[rd_index];

endmodule

// File: tb/tb_inst_mem_resp.sv
// tb/tb_inst_mem_resp.sv - randomized scoreboard bench for inst_mem_resp
module tb_inst_mem_resp;

  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk;
  logic          rst_n;
  logic [31:0]   pc_i;
  logic [31:0]   inst_o;
  logic          fetch_err_o;
  logic          hold_o;
  logic          ld_start_i;
  logic [AW-1:0] ld_base_i;
  logic [15:0]   ld_len_i;
  logic          ld_valid_i;
  logic [7:0]    ld_data_i;
  logic          ld_ready_o;
  logic          ld_abort_i;
  logic          ld_done_o;
  logic          ld_err_o;

  inst_mem_resp #(.BASE_ADDR(BASE), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .inst_o(inst_o), .fetch_err_o(fetch_err_o),
    .hold_o(hold_o), .ld_start_i(ld_start_i), .ld_base_i(ld_base_i), .ld_len_i(ld_len_i),
    .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .ld_abort_i(ld_abort_i), .ld_done_o(ld_done_o), .ld_err_o(ld_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
    bit          chk_inst;
  } exp_t;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  exp_t        exp_q[$];
  exp_t        mon_e;
  bit          rd_pend = 1'b0;
  logic [31:0] ld_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: byte offset from the base, bounds on the mathematical value.
  function automatic exp_t model_fetch(input logic [31:0] pc);
    exp_t   e;
    longint off;
    int     idx;
    off        = longint'(pc) - longint'(BASE);
    e.pc       = pc;
    e.err      = (pc % 4 != 0) || (off < 0) || (off >= 4 * DEPTH);
    e.chk_inst = 1'b1;
    e.inst     = NOP;
    if (!e.err) begin
      idx = int'(off / 4);
      if (ref_known[idx]) e.inst = ref_mem[idx];
      else e.chk_inst = 1'b0;
    end
    return e;
  endfunction

  task automatic fetch(input logic [31:0] pc);
    @(posedge clk); #1;
    pc_i = pc;
    exp_q.push_back(model_fetch(pc));
    rd_pend = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rd_pend) begin
      rd_pend = 1'b0;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL fetch_pop: no expected entry queued");
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("fetch_err pc=%h", mon_e.pc), {31'd0, fetch_err_o}, {31'd0, mon_e.err});
        if (mon_e.chk_inst) check($sformatf("inst pc=%h", mon_e.pc), inst_o, mon_e.inst);
      end
    end
  end

  // mode 0: complete load; 1: abort when stop_at bytes accepted; 2: async reset at that point.
  task automatic do_load(input logic [AW-1:0] base, input int stop_at, input int mode,
                         input bit gaps, input bit poke);
    int          n;
    int          total;
    int          b;
    int          idx;
    logic [31:0] w;
    n     = ld_words.size();
    total = 4 * n;
    b     = 0;
    @(posedge clk); #1;
    ld_start_i = 1'b1;
    ld_base_i  = base;
    ld_len_i   = 16'(n);
    @(negedge clk);
    check("hold_start_cycle", {31'd0, hold_o}, 0);
    check("ready_start_cycle", {31'd0, ld_ready_o}, 0);
    @(posedge clk); #1;
    ld_start_i = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      check("done_len0", {31'd0, ld_done_o}, 1);
      check("ready_len0", {31'd0, ld_ready_o}, 0);
      check("hold_len0", {31'd0, hold_o}, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_after_len0", {31'd0, ld_done_o}, 0);
      check("hold_after_len0", {31'd0, hold_o}, 0);
      return;
    end
    while (b < total) begin
      if (mode != 0 && b == stop_at) begin
        if (mode == 1) begin
          ld_abort_i = 1'b1;
          ld_valid_i = 1'b1;
          ld_data_i  = 8'($urandom);
          @(negedge clk);
          check("err_pulse", {31'd0, ld_err_o}, 1);
          check("done_on_abort", {31'd0, ld_done_o}, 0);
          @(posedge clk); #1;
          ld_abort_i = 1'b0;
          ld_valid_i = 1'b0;
          @(negedge clk);
          check("err_after_abort", {31'd0, ld_err_o}, 0);
          check("hold_after_abort", {31'd0, hold_o}, 0);
          check("ready_after_abort", {31'd0, ld_ready_o}, 0);
          check("done_after_abort", {31'd0, ld_done_o}, 0);
        end else begin
          #2;
          rst_n = 1'b0;
          #1;
          check("ready_async_rst", {31'd0, ld_ready_o}, 0);
          check("hold_async_rst", {31'd0, hold_o}, 0);
          ld_valid_i = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
        end
        return;
      end
      w          = ld_words[b / 4];
      ld_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      ld_data_i  = w[8 * (b % 4) +: 8];
      if (poke) begin
        ld_start_i = 1'($urandom_range(0, 1));
        ld_base_i  = AW'($urandom);
        ld_len_i   = 16'($urandom);
      end
      @(negedge clk);
      check("ready_loading", {31'd0, ld_ready_o}, 1);
      check("hold_loading", {31'd0, hold_o}, 1);
      check("done_loading", {31'd0, ld_done_o}, 0);
      check("inst_nop_busy", inst_o, NOP);
      @(posedge clk);
      if (ld_valid_i) begin
        if (b % 4 == 3) begin
          idx            = (int'(base) + b / 4) % DEPTH;
          ref_mem[idx]   = w;
          ref_known[idx] = 1'b1;
        end
        b++;
      end
      #1;
    end
    ld_valid_i = 1'b0;
    ld_start_i = 1'b0;
    @(negedge clk);
    check("done_pulse", {31'd0, ld_done_o}, 1);
    check("ready_in_done", {31'd0, ld_ready_o}, 0);
    check("hold_in_done", {31'd0, hold_o}, 1);
    check("err_in_done", {31'd0, ld_err_o}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_one_cycle", {31'd0, ld_done_o}, 0);
    check("hold_released", {31'd0, hold_o}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int sel;
    rst_n      = 1'b0;
    pc_i       = 32'd0;
    ld_start_i = 1'b0;
    ld_base_i  = '0;
    ld_len_i   = 16'd0;
    ld_valid_i = 1'b0;
    ld_data_i  = 8'd0;
    ld_abort_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_hold", {31'd0, hold_o}, 0);
    check("rst_ready", {31'd0, ld_ready_o}, 0);
    check("rst_done", {31'd0, ld_done_o}, 0);
    check("rst_err", {31'd0, ld_err_o}, 0);
    fetch(32'h0);
    fetch(32'h2);

    ld_words = '{32'h0050_0093, 32'h0010_0513};
    do_load(AW'(0), 0, 0, 1'b0, 1'b0);
    fetch(32'h0);
    fetch(32'h4);

    ld_words = '{$urandom, $urandom};
    do_load(AW'(1023), 0, 0, 1'b0, 1'b0);
    fetch(32'hFFC);
    fetch(32'h0);
    fetch(32'h1000);
    fetch(32'hFFFF_FFFC);
    fetch(32'h0000_1FFC);

    ld_words = '{$urandom, $urandom};
    do_load(AW'(16), 0, 0, 1'b0, 1'b0);
    ld_words = '{$urandom, $urandom};
    do_load(AW'(16), 6, 1, 1'b0, 1'b0);
    fetch(32'h40);
    fetch(32'h44);

    ld_words.delete();
    do_load(AW'(0), 0, 0, 1'b0, 1'b0);
    fetch(32'h0);

    ld_words = '{$urandom, $urandom, $urandom};
    do_load(AW'(100), 0, 0, 1'b1, 1'b1);
    fetch(32'd400);
    fetch(32'd404);
    fetch(32'd408);

    repeat (6) begin
      n        = $urandom_range(1, 4);
      ld_words.delete();
      repeat (n) ld_words.push_back($urandom);
      if ($urandom_range(0, 2) == 0)
        do_load(AW'($urandom), $urandom_range(0, 4 * n - 1), 1, 1'b1, 1'($urandom_range(0, 1)));
      else
        do_load(AW'($urandom), 0, 0, 1'b1, 1'($urandom_range(0, 1)));
    end
    repeat (40) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       fetch(32'($urandom_range(0, DEPTH - 1)) << 2);
        1:       fetch($urandom);
        2:       fetch(32'hFF0 + 32'($urandom_range(0, 8)) * 4);
        default: fetch((32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3)));
      endcase
    end

    ld_words = '{$urandom, $urandom, $urandom};
    do_load(AW'(32), 5, 2, 1'b0, 1'b0);
    fetch(32'h80);
    fetch(32'h0);

    repeat (3) @(posedge clk);
    check("queue_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
